// File: rtl/imem_pkg.sv
// Shared types and limits for the latency-configurable instruction memory.
package imem_pkg;

    localparam int CNT_W   = 4;
    localparam int LAT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/m_imem_array.sv
// Instruction word storage with a registered synchronous read port.
// Contents are preloaded from simulation through the hierarchical name mem.
module m_imem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/m_imem_lat.sv
// Instruction memory with programmable fetch latency and w_re/w_oe/w_busy handshake.
// Optional IMEM_LAST_HIT_EN: a repeat fetch of the last responded index answers in one cycle.
module m_imem_lat
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [31:0]       w_pc,
    input  logic              w_re,
    output logic [DATA_W-1:0] w_ir,
    output logic              w_oe,
    output logic              w_busy
);

    localparam int LAT_C = (LATENCY < 1) ? 1 : ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LAT_C > 1) ? LAT_C - 2 : 0);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] idx_q, idx_nx;
    logic [ADDR_W-1:0] pc_idx, rd_idx;
    logic              rd_en;
    logic              hit;
    logic              unused_pc;

    assign pc_idx    = w_pc[ADDR_W+1:2];
    assign unused_pc = ^{w_pc[31:ADDR_W+2], w_pc[1:0]};

`ifdef IMEM_LAST_HIT_EN
    logic [ADDR_W-1:0] last_idx;
    logic              last_vld;

    assign hit = last_vld && (pc_idx == last_idx);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            last_vld <= 1'b0;
            last_idx <= '0;
        end else if (rd_en) begin
            last_vld <= 1'b1;
            last_idx <= rd_idx;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx_q <= idx_nx;
        end
    end

    // The array read fires on the edge entering RESP, so w_ir only moves on a response.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx_q;
        rd_idx   = idx_q;
        rd_en    = 1'b0;
        w_oe     = 1'b0;
        w_busy   = 1'b0;
        case (state)
            IDLE, RESP: begin
                w_oe = (state == RESP);
                if (w_re) begin
                    idx_nx = pc_idx;
                    rd_idx = pc_idx;
                    if (LAT_C == 1 || hit) begin
                        state_nx = RESP;
                        rd_en    = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (cnt == '0) begin
                    state_nx = RESP;
                    rd_en    = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    m_imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (w_ir)
    );

endmodule

// File: tb/tb_m_imem_lat.sv
// Self-checking bench for m_imem_lat: four configurations driven side by side,
// checked every cycle against a transaction-level latency model.
module tb_m_imem_lat;

    localparam int ND = 4;
`ifdef IMEM_LAST_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    function automatic int cfg_lat(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_aw(input int g);
        return (g == 3) ? 4 : 10;
    endfunction

    function automatic logic [31:0] mem_val(input int g, input int i);
        if (i == 4) return 32'h00500093;
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(g << 28) ^ 32'(i);
    endfunction

    logic        clk;
    logic        rst  [ND];
    logic        re   [ND];
    logic [31:0] pc   [ND];
    logic [31:0] ir   [ND];
    logic        oe   [ND];
    logic        busy [ND];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int AW = cfg_aw(g);

        m_imem_lat #(
            .ADDR_W  (AW),
            .DATA_W  (32),
            .LATENCY (cfg_lat(g))
        ) u_dut (
            .w_clk  (clk),
            .w_rst  (rst[g]),
            .w_pc   (pc[g]),
            .w_re   (re[g]),
            .w_ir   (ir[g]),
            .w_oe   (oe[g]),
            .w_busy (busy[g])
        );

        initial begin
            logic [AW-1:0] a;
            for (int i = 0; i < (1 << AW); i++) begin
                a = AW'(i);
                u_dut.u_array.mem[a] = mem_val(g, i);
            end
        end
    end

    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: one outstanding fetch, response visible lat-1 edges after acceptance.
    bit          m_pend [ND];
    int          m_left [ND];
    int          m_idx  [ND];
    logic [31:0] m_ir   [ND];
    bit          m_oe   [ND];
    bit          m_lv   [ND];
    int          m_li   [ND];

    task automatic respond(input int k);
        m_oe[k] = 1'b1;
        m_ir[k] = mem_val(k, m_idx[k]);
        m_lv[k] = 1'b1;
        m_li[k] = m_idx[k];
    endtask

    task automatic model_step(input int k);
        int idx;
        int lat;
        if (rst[k]) begin
            m_pend[k] = 1'b0;
            m_oe[k]   = 1'b0;
            m_ir[k]   = '0;
            m_lv[k]   = 1'b0;
        end else begin
            m_oe[k] = 1'b0;
            if (m_pend[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_pend[k] = 1'b0;
                    respond(k);
                end
            end else if (re[k]) begin
                idx = int'(pc[k][31:2]) % (1 << cfg_aw(k));
                lat = cfg_lat(k);
                if (HIT_EN && m_lv[k] && m_li[k] == idx) lat = 1;
                m_idx[k] = idx;
                if (lat == 1) begin
                    respond(k);
                end else begin
                    m_pend[k] = 1'b1;
                    m_left[k] = lat - 1;
                end
            end
        end
    endtask

    task automatic step_and_check();
        @(posedge clk);
        for (int k = 0; k < ND; k++) model_step(k);
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("d%0d_oe", k),   32'(oe[k]),   32'(m_oe[k]));
            chk($sformatf("d%0d_busy", k), 32'(busy[k]), 32'(m_pend[k]));
            chk($sformatf("d%0d_ir", k),   ir[k],        m_ir[k]);
        end
    endtask

    initial begin
        int          c;
        int          n_oe0, n_busy0, n_oe1, n_busy1;
        logic [31:0] ir0;
        int          d2_n;
        int          d2_cyc2;
        logic [31:0] d2_ir1;
        int          d3_rec, d3_rep, d3_c;

        n_chk = 0;
        n_bad = 0;
        n_oe0 = 0; n_busy0 = 0; n_oe1 = 0; n_busy1 = 0;
        ir0 = '0; d2_n = 0; d2_cyc2 = -1; d2_ir1 = '0;
        d3_rec = -1; d3_rep = -1; d3_c = -1;
        for (int k = 0; k < ND; k++) begin
            rst[k] = 1'b1; re[k] = 1'b0; pc[k] = '0;
            m_pend[k] = 1'b0; m_left[k] = 0; m_idx[k] = 0;
            m_ir[k] = '0; m_oe[k] = 1'b0; m_lv[k] = 1'b0; m_li[k] = 0;
        end
        step_and_check();
        step_and_check();

        // Directed scenarios, one per instance, run concurrently.
        for (int t = 0; t < 32; t++) begin
            for (int k = 0; k < ND; k++) begin
                rst[k] = 1'b0; re[k] = 1'b0; pc[k] = '0;
            end
            if (t == 0) begin re[0] = 1'b1; pc[0] = 32'h10; end
            if (t < 4)  begin re[1] = 1'b1; pc[1] = 32'(t * 4); end
            if (t < 9)  begin re[2] = 1'b1; pc[2] = (t < 2) ? 32'h20 : 32'h24; end
            case (t)
                0:         begin re[3] = 1'b1; pc[3] = 32'h43; end
                6, 10, 16: begin re[3] = 1'b1; pc[3] = 32'h8;  end
                8:         rst[3] = 1'b1;
                22:        begin re[3] = 1'b1; pc[3] = 32'hC;  end
                default:   ;
            endcase
            step_and_check();
            c = t + 1;
            if (oe[0]) begin n_oe0++; ir0 = ir[0]; end
            if (busy[0]) n_busy0++;
            if (oe[1]) n_oe1++;
            if (busy[1]) n_busy1++;
            if (oe[2]) begin
                d2_n++;
                if (d2_n == 1) d2_ir1 = ir[2];
                if (d2_n == 2) d2_cyc2 = c;
            end
            if (oe[3] && c > 9  && d3_rec < 0) d3_rec = c;
            if (oe[3] && c > 16 && d3_rep < 0) d3_rep = c;
            if (oe[3] && c > 22 && d3_c < 0)   d3_c = c;
        end
        chk("lat3_oe_count",    32'(n_oe0),   32'd1);
        chk("lat3_busy_cycles", 32'(n_busy0), 32'd2);
        chk("lat3_ir",          ir0,          32'h00500093);
        chk("lat1_oe_count",    32'(n_oe1),   32'd4);
        chk("lat1_busy_cycles", 32'(n_busy1), 32'd0);
        chk("lat4_first_ir",    d2_ir1,       mem_val(2, 8));
        chk("lat4_second_cyc",  32'(d2_cyc2), 32'd8);
        chk("lat5_after_rst",   32'(d3_rec),  32'd15);
        chk("lat5_repeat_cyc",  32'(d3_rep),  HIT_EN ? 32'd17 : 32'd21);
        chk("lat5_new_cyc",     32'(d3_c),    32'd27);

        // Randomised traffic with occasional resets and a small address pool for repeats.
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < ND; k++) begin
                rst[k] = ($urandom_range(0, 99) == 0);
                re[k]  = ($urandom_range(0, 2) != 0);
                pc[k]  = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            end
            step_and_check();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
